// File: rtl/core_sequencer.sv
// Core sequencer: steps one fetched instruction through latch, PC update,
// core start and completion wait, with a per-instruction watchdog and UART mux.
module core_sequencer #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 8,
    parameter int INSTR_W   = 16,
    parameter int TMO_W     = 16,
    parameter int SEL_W     = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SEL_W-1:0]       core_sel,
    input  logic                   fetch_done,
    input  logic [INSTR_W-1:0]     instr_in,
    input  logic [ADDR_W-1:0]      pc_next,
    output logic [ADDR_W-1:0]      pc,
    output logic                   pc_en,
    output logic [INSTR_W-1:0]     instr_out,
    output logic [NUM_CORES-1:0]   run,
    input  logic [NUM_CORES-1:0]   core_done,
    input  logic                   fetch_tx_en,
    input  logic [7:0]             fetch_tx_data,
    input  logic [NUM_CORES-1:0]   core_tx_en,
    input  logic [8*NUM_CORES-1:0] core_tx_data,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    output logic                   fetch_hold,
    input  logic [TMO_W-1:0]       tmo_limit,
    output logic                   err,
    output logic [SEL_W-1:0]       err_core,
    output logic [15:0]            instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_PCUPD, S_RUN, S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [SEL_W-1:0]   errc_q, errc_d;
    logic [TMO_W-1:0]   wdog_q, wdog_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               io_q, io_d;

    logic               done_sel;
    logic               ctx_en;
    logic [7:0]         ctx_data;
    logic               own;
    logic               tmo_hit;

    assign pc        = pc_q;
    assign instr_out = instr_q;
    assign instr_cnt = cnt_q;
    assign err       = err_q;
    assign err_core  = errc_q;
    assign tmo_hit   = (tmo_limit != '0) && (wdog_q == tmo_limit);

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            errc_q  <= '0;
            wdog_q  <= '0;
            sel_q   <= '0;
            io_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            errc_q  <= errc_d;
            wdog_q  <= wdog_d;
            sel_q   <= sel_d;
            io_q    <= io_d;
        end
    end

    // Next state: sequence one instruction; done beats a coincident timeout
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        errc_d  = errc_q;
        wdog_d  = wdog_q;
        sel_d   = sel_q;
        io_d    = io_q;
        unique case (state_q)
            S_IDLE: begin
                if (fetch_done) begin
                    instr_d = instr_in;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                sel_d   = (32'(core_sel) >= NUM_CORES) ? '0 : core_sel;
                io_d    = (instr_q[1:0] == 2'b11);
                state_d = S_PCUPD;
            end
            S_PCUPD: begin
                pc_d    = pc_next;
                state_d = S_RUN;
            end
            S_RUN: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_sel) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    errc_d  = sel_q;
                    state_d = S_IDLE;
                end else begin
                    wdog_d  = wdog_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: strobes from state, selected-core muxing and UART ownership
    always_comb begin
        run      = '0;
        done_sel = 1'b0;
        ctx_en   = 1'b0;
        ctx_data = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                run[i]   = (state_q == S_RUN);
                done_sel = core_done[i];
                ctx_en   = core_tx_en[i];
                ctx_data = core_tx_data[8*i +: 8];
            end
        end
        own        = io_q && ((state_q == S_RUN) || (state_q == S_WAIT));
        pc_en      = (state_q == S_PCUPD);
        fetch_hold = own;
        tx_en      = own ? ctx_en : fetch_tx_en;
        tx_data    = own ? ctx_data : fetch_tx_data;
    end

endmodule
